dm_responder: RTL

Memory-side responder for the CPU data-memory port: accepts one load or store request at a time over a valid/ready handshake, models a configurable number of wait states, and returns read data or a write acknowledgement over a second valid/ready handshake. It sits between the CPU's data-memory request logic and a word-organised storage array held inside the block. It replaces the zero-latency RAM when multi-cycle memory and CPU stall logic are exercised.

---
 rtl/dm_responder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/dm_responder.sv
// dm_responder
//   Memory-side responder for the CPU data-memory port. It takes one load or
//   store at a time, inserts WAIT_CYCLES wait states, performs the access
//   against an internal 2**ADDR_W x 32 word array, then presents the result
//   until the requester takes it.
//
// Ports
//   clk         rising-edge clock
//   clr_n       asynchronous active-low reset
//   req_valid   request present
//   req_ready   responder idle and able to accept (decoded from state only)
//   req_write   1 = store, 0 = load
//   req_addr    word address
//   req_wdata   store data
//   req_be      store byte enables, bit i covers wdata[8i+7:8i]
//   resp_valid  response present
//   resp_ready  requester consumes response this cycle
//   resp_rdata  load data, 32'h0 for store acknowledgements
//   resp_write  echo of the request's write flag
module dm_responder #(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_be,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_write
);

   localparam int DEPTH = 1 << ADDR_W;

   generate
      if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
         $error("dm_responder: WAIT_CYCLES must be in 0..15");
      end
   endgenerate

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
      logic [3:0]        be;
   } req_t;

   state_t      state;
   logic [3:0]  cnt;
   req_t        req_q;
   logic [31:0] mem [DEPTH];
   logic        do_access;

   // The access happens on the edge that leaves WAIT; reset forces state to
   // IDLE asynchronously, so a dropped store can never reach the array.
   assign do_access = (state == S_WAIT) && (cnt == 4'd0);
   assign req_ready = (state == S_IDLE);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state      <= S_IDLE;
         cnt        <= 4'd0;
         req_q      <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0;
         resp_write <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  req_q.write <= req_write;
                  req_q.addr  <= req_addr;
                  req_q.wdata <= req_wdata;
                  req_q.be    <= req_be;
                  cnt         <= WAIT_INIT;
                  state       <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt == 4'd0) begin
                  resp_valid <= 1'b1;
                  resp_write <= req_q.write;
                  resp_rdata <= req_q.write ? 32'h0 : mem[req_q.addr];
                  state      <= S_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_RESP: begin
               // rdata/write stay untouched here so they hold under backpressure
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Storage is deliberately not reset; contents are undefined until written.
   always_ff @(posedge clk) begin
      if (do_access && req_q.write) begin
         for (int i = 0; i < 4; i++) begin
            if (req_q.be[i]) mem[req_q.addr][8*i +: 8] <= req_q.wdata[8*i +: 8];
         end
      end
   end

endmodule
